// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed N-digit 7-segment scan driver with tear-free frame updates
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Pin levels that leave a segment / anode dark.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

    // Scan position
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Pending (double-buffer) frame and the frame currently being scanned
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

    // Registered pin outputs
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;

    logic tick;
    logic boundary;

    // Leading-zero helpers
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_code;
    logic [6:0]            raw_seg;
    logic [NUM_DIGITS-1:0] an_onehot;

    // Active-high g..a glyph for one digit code; hex letters only when enabled.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        g = 7'b0000000;
        case (code)
            4'd0:  g = 7'b0111111;
            4'd1:  g = 7'b0000110;
            4'd2:  g = 7'b1011011;
            4'd3:  g = 7'b1001111;
            4'd4:  g = 7'b1100110;
            4'd5:  g = 7'b1101101;
            4'd6:  g = 7'b1111101;
            4'd7:  g = 7'b0000111;
            4'd8:  g = 7'b1111111;
            4'd9:  g = 7'b1101111;
            4'd10: g = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
            4'd11: g = (HEX_MODE != 0) ? 7'b1111100 : 7'b0000000;
            4'd12: g = (HEX_MODE != 0) ? 7'b0111001 : 7'b0000000;
            4'd13: g = (HEX_MODE != 0) ? 7'b1011110 : 7'b0000000;
            4'd14: g = (HEX_MODE != 0) ? 7'b1111001 : 7'b0000000;
            4'd15: g = (HEX_MODE != 0) ? 7'b1110001 : 7'b0000000;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    assign tick     = (psc_q == PSC_MAX);
    assign boundary = tick && (idx_q == IDX_MAX);

    // Prescaler and digit index advance; index wraps after the last digit.
    always_comb begin
        psc_d = psc_q + PSC_W'(1);
        idx_d = idx_q;
        if (tick) begin
            psc_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Double buffering: loads park in pending and only reach the display at a
    // frame boundary, so a frame is never drawn half old and half new. A load
    // landing on the boundary itself bypasses pending.
    always_comb begin
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_bcd_d   = disp_bcd_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            pend_bcd_d   = bcd_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
        if (boundary) begin
            pend_valid_d = 1'b0;
            if (load) begin
                disp_bcd_d = bcd_in;
                disp_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                disp_bcd_d = pend_bcd_q;
                disp_dp_d  = pend_dp_q;
            end
        end
    end

    // Digit i (i>0) is a leading zero when it and every digit above it are 0.
    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run      = lz_run & (disp_bcd_q[4*i +: 4] == 4'd0);
            lz_blank[i] = lz_run & (i != 0);
        end
    end

    // Decode the digit under the scan pointer and apply pin polarities.
    always_comb begin
        cur_code  = disp_bcd_q[4*int'(idx_q) +: 4];
        raw_seg   = (blank_lz && lz_blank[idx_q]) ? 7'b0000000 : glyph(cur_code);
        an_onehot = NUM_DIGITS'(1) << idx_q;
        seg_d     = (SEG_ACTIVE_LOW != 0) ? ~raw_seg : raw_seg;
        dp_d      = (SEG_ACTIVE_LOW != 0) ? ~disp_dp_q[idx_q] : disp_dp_q[idx_q];
        an_d      = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
        fs_d      = (idx_q == '0) && (psc_q == '0);
    end

    // State and output registers; reset blanks the pins immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q        <= '0;
            idx_q        <= '0;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            fs_q         <= 1'b0;
        end else begin
            psc_q        <= psc_d;
            idx_q        <= idx_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank_lz;
    logic [6:0]    seg0, seg1;
    logic          dp0, dp1;
    logic [3:0]    an0, an1;
    logic          fs0, fs1;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(0),
                            .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_dec (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0));

    seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(1),
                            .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1));

    logic [6:0] glyph_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic        blz;
        logic [27:0] s_dec;   // {d3,d2,d1,d0}
        logic [27:0] s_hex;
    } vec_t;

    vec_t tbl [6];

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;           // rising edges since reset release

    logic [15:0] m_bcd, m_pbcd;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] ref_seg(input logic [15:0] f, input int d,
                                           input logic blz, input int hex);
        int msd;
        logic [3:0] code;
        msd = 0;
        for (int i = 0; i < ND; i++) if (f[4*i +: 4] != 4'd0) msd = i;
        if (blz && d > msd) return 7'b0000000;
        code = f[4*d +: 4];
        if (code < 4'd10 || hex != 0) return glyph_tab[code];
        return 7'b0000000;
    endfunction

    task automatic model_reset();
        k = 0; m_bcd = '0; m_dp = '0; m_pbcd = '0; m_pdp = '0; m_pv = 1'b0;
    endtask

    // One clock: predict what the pins show after this edge, then advance the model.
    task automatic cycle();
        int d;
        logic [6:0] e0, e1;
        logic edp, efs;
        logic [3:0] ean;
        @(posedge clk);
        k++;
        d   = ((k - 1) / SD) % ND;
        e0  = ref_seg(m_bcd, d, blank_lz, 0);
        e1  = ref_seg(m_bcd, d, blank_lz, 1);
        edp = m_dp[d];
        ean = ~(4'b0001 << d);
        efs = ((k - 1) % FRAME) == 0;
        if (load) begin
            if (k % FRAME == 0) begin
                m_bcd = bcd_in; m_dp = dp_in; m_pv = 1'b0;
            end else begin
                m_pbcd = bcd_in; m_pdp = dp_in; m_pv = 1'b1;
            end
        end else if ((k % FRAME == 0) && m_pv) begin
            m_bcd = m_pbcd; m_dp = m_pdp; m_pv = 1'b0;
        end
        @(negedge clk);
        check("out_dec", 32'({seg0, dp0, an0, fs0}), 32'({e0, edp, ean, efs}));
        check("out_hex", 32'({seg1, dp1, an1, fs1}), 32'({e1, edp, ean, efs}));
    endtask

    task automatic run_to(input int phase);
        for (int n = 0; n < FRAME && (k % FRAME) != phase; n++) cycle();
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (!fs0 && n < 3 * FRAME) begin cycle(); n++; end
        check("frame_start_seen", 32'(fs0), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] p);
        bcd_in = b; dp_in = p; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    function automatic int lit_digit(input logic [3:0] a);
        int r;
        r = -1;
        for (int i = 0; i < ND; i++) if (a[i] == 1'b0) r = i;
        return r;
    endfunction

    initial begin
        int d, fs_cnt;
        logic [15:0] mask;

        tbl[0] = '{16'h1234, 4'b0100, 1'b0,
                   {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110},
                   {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}};
        tbl[1] = '{16'h0050, 4'b0000, 1'b1,
                   {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111},
                   {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}};
        tbl[2] = '{16'h0000, 4'b0001, 1'b1,
                   {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111},
                   {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}};
        tbl[3] = '{16'hFA0C, 4'b1000, 1'b0,
                   {7'b0000000, 7'b0000000, 7'b0111111, 7'b0000000},
                   {7'b1110001, 7'b1110111, 7'b0111111, 7'b0111001}};
        tbl[4] = '{16'h0050, 4'b1010, 1'b0,
                   {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111},
                   {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111}};
        tbl[5] = '{16'hFA0C, 4'b0000, 1'b1,
                   {7'b0000000, 7'b0000000, 7'b0111111, 7'b0000000},
                   {7'b1110001, 7'b1110111, 7'b0111111, 7'b0111001}};

        rst_n = 1'b0; bcd_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
        model_reset();
        #12;
        check("reset_dec", 32'({seg0, dp0, an0, fs0}), 32'({7'b0, 1'b0, 4'hF, 1'b0}));
        check("reset_hex", 32'({seg1, dp1, an1, fs1}), 32'({7'b0, 1'b0, 4'hF, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan: two full frames of zeros, two frame_start pulses.
        fs_cnt = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            cycle();
            if (fs0) fs_cnt++;
        end
        check("fs_per_2_frames", 32'(fs_cnt), 32'd2);

        // Table: load mid digit 1, then verify the following frame digit by digit.
        for (int t = 0; t < 6; t++) begin
            blank_lz = tbl[t].blz;
            run_to(5);
            do_load(tbl[t].bcd, tbl[t].dpv);
            wait_fs();
            for (int j = 0; j < FRAME; j++) begin
                if (j % SD == 0) begin
                    d = lit_digit(an0);
                    if (d < 0) check("tbl_an", 32'(an0), 32'hE);
                    else begin
                        check("tbl_dec", 32'({seg0, dp0}), 32'({tbl[t].s_dec[7*d +: 7], tbl[t].dpv[d]}));
                        check("tbl_hex", 32'({seg1, dp1}), 32'({tbl[t].s_hex[7*d +: 7], tbl[t].dpv[d]}));
                    end
                end
                cycle();
            end
        end
        blank_lz = 1'b0;

        // Two loads before one boundary: only the second is ever shown.
        run_to(3);
        do_load(16'h1111, 4'b0000);
        cycle(); cycle();
        do_load(16'h2222, 4'b0000);
        wait_fs();
        for (int j = 0; j < FRAME; j++) begin
            check("last_load_wins", 32'(seg0), 32'(7'b1011011));
            cycle();
        end

        // Load on the exact boundary cycle appears in the very next frame.
        run_to(15);
        do_load(16'h5678, 4'b0000);
        cycle();
        check("boundary_load_fs", 32'(fs0), 32'd1);
        check("boundary_load_seg", 32'(seg0), 32'(7'b1111111));
        for (int n = 0; n < FRAME; n++) cycle();

        // Reset mid digit 2 with a pending load: pins go dark at once, load discarded.
        run_to(6);
        do_load(16'h9999, 4'b1111);
        run_to(10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dec", 32'({seg0, dp0, an0, fs0}), 32'({7'b0, 1'b0, 4'hF, 1'b0}));
        check("async_rst_hex", 32'({seg1, dp1, an1, fs1}), 32'({7'b0, 1'b0, 4'hF, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle();
        check("post_rst_first", 32'({seg0, an0, fs0}), 32'({7'b0111111, 4'b1110, 1'b1}));
        for (int n = 0; n < 2 * FRAME; n++) cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                default: mask = 16'h000F;
            endcase
            bcd_in = 16'($urandom) & mask;
            dp_in  = 4'($urandom);
            load   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            cycle();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
